// File: rtl/sweep_pkg.sv
// sweep_pkg: shared widths, FSM state encoding and mode constants for the sweep controller.
package sweep_pkg;
    localparam int FW = 8;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_TRI = 1'b1;
    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN} state_t;
endpackage

// File: rtl/sweep_freq_ctrl_if.sv
// sweep_freq_ctrl_if: config/control inputs and status outputs of the sweep controller.
interface sweep_freq_ctrl_if
    import sweep_pkg::*;
#(
    parameter int W_F = FW,
    parameter int W_D = DW,
    parameter int W_S = SW
);
    logic           start;
    logic           stop;
    logic           mode;
    logic [W_F-1:0] f_lo;
    logic [W_F-1:0] f_hi;
    logic [W_S-1:0] step;
    logic [W_D-1:0] rate_div;
    logic [W_F-1:0] freq_word;
    logic           busy;
    logic           sweep_done;
    logic           cfg_err;
    modport master(
        output start, stop, mode, f_lo, f_hi, step, rate_div,
        input  freq_word, busy, sweep_done, cfg_err
    );
    modport slave(
        input  start, stop, mode, f_lo, f_hi, step, rate_div,
        output freq_word, busy, sweep_done, cfg_err
    );
endinterface

// File: rtl/sweep_tick_gen.sv
// sweep_tick_gen: prescaler producing a tick every div+1 enabled cycles.
module sweep_tick_gen
    import sweep_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] count;

    assign tick = en && !clr && count == div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else count <= (clr || !en || tick) ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/sweep_freq_ctrl.sv
// sweep_freq_ctrl: ramps the phase-accumulator increment between latched bounds,
// one-shot or as a continuous triangle, paced by a prescaler.
module sweep_freq_ctrl
    import sweep_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    sweep_freq_ctrl_if.slave bus
);
    state_t        state;
    logic [FW-1:0] freq, lo, hi;
    logic [SW-1:0] stp;
    logic [DW-1:0] div;
    logic          md, done, err, tick, start_ok;
    logic [FW:0]   stp_ext, up;

    assign start_ok = bus.start && bus.f_lo <= bus.f_hi;
    assign stp_ext  = {{(FW + 1 - SW){1'b0}}, stp};
    assign up       = {1'b0, freq} + stp_ext;

    sweep_tick_gen #(.W(DW)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != IDLE),
        .clr  (bus.stop || start_ok),
        .div  (div),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            freq  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            lo    <= '0;
            hi    <= '0;
            stp   <= '0;
            div   <= '0;
            md    <= MODE_ONESHOT;
        end else begin
            done <= 1'b0;
            if (bus.stop) begin
                state <= IDLE;
                freq  <= '0;
            end else if (start_ok) begin
                lo    <= bus.f_lo;
                hi    <= bus.f_hi;
                stp   <= bus.step == '0 ? SW'(1) : bus.step;
                div   <= bus.rate_div;
                md    <= bus.mode;
                freq  <= bus.f_lo;
                state <= RAMP_UP;
                err   <= 1'b0;
            end else begin
                if (bus.start) err <= 1'b1;
                // sums are one bit wider so neither direction can wrap past a bound
                if (tick) case (state)
                    RAMP_UP:
                        if (up >= {1'b0, hi}) begin
                            freq  <= hi;
                            state <= HOLD_HI;
                        end else freq <= up[FW-1:0];
                    HOLD_HI: begin
                        freq  <= hi;
                        state <= md == MODE_TRI ? RAMP_DOWN : IDLE;
                        done  <= md != MODE_TRI;
                    end
                    RAMP_DOWN:
                        if ({1'b0, freq} <= {1'b0, lo} + stp_ext) begin
                            freq  <= lo;
                            state <= RAMP_UP;
                            done  <= 1'b1;
                        end else freq <= freq - stp_ext[FW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.freq_word  = freq;
    assign bus.busy       = state != IDLE;
    assign bus.sweep_done = done;
    assign bus.cfg_err    = err;
endmodule

// File: tb/tb_sweep_freq_ctrl.sv
// tb_sweep_freq_ctrl: directed vectors with hand-computed expectations for sweep_freq_ctrl.
module tb_sweep_freq_ctrl;
    import sweep_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sweep_freq_ctrl_if bus();

    sweep_freq_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] st,
                      input logic [7:0] dv, input logic md);
        bus.f_lo = lo;
        bus.f_hi = hi;
        bus.step = st;
        bus.rate_div = dv;
        bus.mode = md;
        bus.start = 1'b1;
        edge1();
        bus.start = 1'b0;
    endtask

    int tri_f[9] = '{0, 3, 6, 8, 8, 5, 2, 0, 3};

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0;
        bus.f_lo = 0; bus.f_hi = 0; bus.step = 0; bus.rate_div = 0;
        repeat (2) edge1();
        check("rst_freq", bus.freq_word, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.sweep_done, 0);
        check("rst_err", bus.cfg_err, 0);
        rst_n = 1'b1;
        edge1();

        // one-shot 10..20 step 4
        go(10, 20, 4, 0, MODE_ONESHOT);
        check("os_k", bus.freq_word, 10);
        check("os_busy", bus.busy, 1);
        edge1(); check("os_k1", bus.freq_word, 14);
        edge1(); check("os_k2", bus.freq_word, 18);
        edge1(); check("os_k3", bus.freq_word, 20);
        check("os_k3_done", bus.sweep_done, 0);
        edge1(); check("os_k4", bus.freq_word, 20);
        check("os_k4_done", bus.sweep_done, 1);
        check("os_k4_busy", bus.busy, 0);
        edge1(); check("os_k5_done", bus.sweep_done, 0);
        check("os_k5_hold", bus.freq_word, 20);

        // triangle 0..8 step 3
        go(0, 8, 3, 0, MODE_TRI);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) edge1();
            check($sformatf("tri_f%0d", i), bus.freq_word, tri_f[i]);
            check($sformatf("tri_d%0d", i), bus.sweep_done, i == 7);
        end
        check("tri_busy", bus.busy, 1);

        // stop during RAMP_DOWN (freq 5)
        go(0, 8, 3, 0, MODE_TRI);
        repeat (5) edge1();
        check("stop_pre", bus.freq_word, 5);
        bus.stop = 1'b1;
        edge1();
        bus.stop = 1'b0;
        check("stop_freq", bus.freq_word, 0);
        check("stop_busy", bus.busy, 0);
        check("stop_done", bus.sweep_done, 0);

        // prescaler div=3
        go(0, 255, 1, 3, MODE_ONESHOT);
        check("pre_k", bus.freq_word, 0);
        for (int i = 1; i <= 12; i++) begin
            edge1();
            check($sformatf("pre_%0d", i), bus.freq_word, i / 4);
        end

        // saturation without wrap
        go(245, 250, 15, 0, MODE_ONESHOT);
        check("sat_k", bus.freq_word, 245);
        edge1(); check("sat_k1", bus.freq_word, 250);

        // step 0 acts as 1
        go(0, 10, 0, 0, MODE_ONESHOT);
        check("s0_k", bus.freq_word, 0);
        edge1(); check("s0_k1", bus.freq_word, 1);
        edge1(); check("s0_k2", bus.freq_word, 2);

        // degenerate lo == hi
        go(7, 7, 5, 0, MODE_ONESHOT);
        check("eq_k", bus.freq_word, 7);
        edge1(); check("eq_k1", bus.freq_word, 7);
        check("eq_k1_done", bus.sweep_done, 0);
        check("eq_k1_busy", bus.busy, 1);
        edge1(); check("eq_k2_done", bus.sweep_done, 1);
        check("eq_k2_busy", bus.busy, 0);
        check("eq_k2_freq", bus.freq_word, 7);

        // rejected start, then a valid one
        go(30, 20, 1, 0, MODE_ONESHOT);
        check("err_set", bus.cfg_err, 1);
        check("err_busy", bus.busy, 0);
        check("err_freq", bus.freq_word, 7);
        go(1, 5, 1, 0, MODE_ONESHOT);
        check("err_clr", bus.cfg_err, 0);
        check("err_freq2", bus.freq_word, 1);

        // stop wins over simultaneous start
        bus.stop = 1'b1;
        go(2, 9, 1, 0, MODE_ONESHOT);
        bus.stop = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_freq", bus.freq_word, 0);

        // asynchronous reset mid RAMP_UP
        go(0, 100, 1, 0, MODE_ONESHOT);
        repeat (3) edge1();
        check("ar_pre", bus.freq_word, 3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_freq", bus.freq_word, 0);
        check("ar_busy", bus.busy, 0);
        edge1();
        rst_n = 1'b1;
        edge1();
        check("ar_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sweep_freq_ctrl.md
Name: sweep_freq_ctrl

Overview:
Frequency-sweep controller sitting directly upstream of the phase accumulator. It drives the accumulator's 8-bit increment word, ramping it between programmable low and high bounds. Steps are paced by a programmable prescaler. Supports one-shot up-sweeps and continuous triangle sweeps, enabling chirps and siren tones from the same phase path.

Parameters:
FW, 8, width of frequency word and bounds
DW, 8, width of prescaler divisor / counter
SW, 4, width of step input

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  1-cycle pulse: latch config, begin sweep
stop  in  1  sync abort to IDLE, mute output
mode  in  1  0 = one-shot up-sweep, 1 = continuous triangle
f_lo  in  FW  lower bound
f_hi  in  FW  upper bound
step  in  SW  increment per tick (0 treated as 1)
rate_div  in  DW  tick every rate_div+1 cycles
freq_word  out  FW  registered increment to phase accumulator
busy  out  1  high in any state except IDLE
sweep_done  out  1  1-cycle pulse at end of sweep / triangle period
cfg_err  out  1  sticky: last start rejected (f_lo > f_hi)

Behaviour:
- Interface (decided): reset rst_n, asynchronous, active-low; clock clk.
- Reset: state IDLE, freq_word=0, busy=0, sweep_done=0, cfg_err=0, prescaler=0, latched config=0.
- All outputs registered; no combinational input-to-output paths.
- Config (f_lo, f_hi, step, mode, rate_div) is latched on an accepted start. Input changes mid-sweep are ignored.
- Start accepted when f_lo <= f_hi. On the next edge: freq_word=f_lo, state RAMP_UP, prescaler=0, cfg_err=0.
- Start rejected when f_lo > f_hi. On the next edge: cfg_err=1, state and freq_word unchanged.
- Start while busy: restart exactly as above.
- stop: on the next edge, state IDLE, freq_word=0, prescaler=0. stop wins over a simultaneous start.
- Prescaler: counts 0..rate_div in non-IDLE states. tick = (count == rate_div); count clears on tick. rate_div=0 gives a tick every cycle. No tick on the start edge itself.
- States and transitions (evaluated only on tick; otherwise hold):
  - IDLE: freq_word holds (f_hi after one-shot completion, 0 after stop/reset). Leaves only on start.
  - RAMP_UP: sum computed at FW+1 bits. If freq_word+step >= f_hi: freq_word=f_hi, go HOLD_HI. Else freq_word += step.
  - HOLD_HI: freq_word=f_hi for one tick. mode=0: go IDLE, sweep_done=1. mode=1: go RAMP_DOWN.
  - RAMP_DOWN: if freq_word <= f_lo+step (FW+1-bit compare, no underflow): freq_word=f_lo, go RAMP_UP, sweep_done=1. Else freq_word -= step.
- Degenerate bounds: f_lo == f_hi makes the first RAMP_UP tick go straight to HOLD_HI.
- sweep_done is high exactly one cycle, coincident with the edge that performs the transition.
- busy is derived from the registered state (state != IDLE).
- Async reset mid-sweep returns all outputs to reset values immediately.

Decomposition:
- Package sweep_pkg: state enum {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN}; FW/DW/SW defaults; mode constants MODE_ONESHOT=0, MODE_TRI=1.
- Sub-module sweep_tick_gen: prescaler counter. Inputs clk, rst_n, en, clr, div; output tick.
- FSM, saturating add/sub and config latch live in the top module.

Test Plan:
- One-shot: lo=10, hi=20, step=4, div=0, mode=0, start at edge k -> freq_word 10,14,18,20 at k..k+3; IDLE at k+4 with sweep_done=1 for one cycle; busy 0; freq_word stays 20.
- Triangle: lo=0, hi=8, step=3, div=0, mode=1 -> 0,3,6,8,8,5,2,0 at k..k+7; sweep_done at k+7; then 3 at k+8; continues indefinitely.
- Prescaler: lo=0, hi=255, step=1, div=3 -> freq_word increments exactly every 4 cycles; first change 4 edges after start.
- Saturation/edges: lo=245, hi=250, step=15 -> 245 then 250 (no wrap to 4). Separately, step=0 behaves as step=1, and lo=hi=7 gives 7 held with done after 2 ticks.
- Config error: lo=30, hi=20, start -> cfg_err=1, busy=0, freq_word unchanged. A subsequent valid start clears cfg_err.
- Abort/reset: stop during RAMP_DOWN -> next edge freq_word=0, IDLE, no sweep_done. stop+start same cycle -> IDLE. rst_n low mid-RAMP_UP -> outputs 0 asynchronously.
